// File: rtl/divide_req_sequencer.sv
// divide_req_sequencer: buffers tagged divide requests and serialises them through the go/done divider
module divide_req_sequencer #(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     reloj,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_dividend,
    input  logic [15:0]              req_divisor,
    input  logic [TAG_W-1:0]         req_tag,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [15:0]              res_quotient,
    output logic [TAG_W-1:0]         res_tag,
    output logic                     res_dz,
    output logic                     res_timeout,
    output logic                     dv_go,
    output logic [31:0]              dv_dd,
    output logic [15:0]              dv_dv,
    input  logic                     dv_done,
    input  logic [2:0]               dv_state,
    input  logic [15:0]              dv_quotient,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 48 + TAG_W;
    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, CAPTURE, RELEASE} state_t;
    state_t            state_q, state_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [EW-1:0]     head;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       count_q, count_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       dd_q, dd_d;
    logic [15:0]       dv_q, dv_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              dz_q, dz_d, go_q, go_d;
    logic              rv_q, rv_d, rdz_q, rdz_d, rto_q, rto_d;
    logic [15:0]       rq_q, rq_d;
    logic [TAG_W-1:0]  rt_q, rt_d;
    logic              push, pop, expired;
    assign req_ready    = count_q != (AW+1)'(DEPTH);
    assign push         = req_valid & req_ready;
    assign pop          = state_q == IDLE && count_q != '0 && !rv_q && dv_done;
    assign expired      = cnt_q == 8'(TIMEOUT_CYC);
    assign head         = mem_q[rd_q];
    assign dv_go        = go_q;
    assign dv_dd        = dd_q;
    assign dv_dv        = dv_q;
    assign busy         = state_q != IDLE;
    assign fifo_count   = count_q;
    assign res_valid    = rv_q;
    assign res_quotient = rq_q;
    assign res_tag      = rt_q;
    assign res_dz       = rdz_q;
    assign res_timeout  = rto_q;
    always_comb begin
        mem_d   = mem_q;
        if (push) mem_d[wr_q] = {req_dividend, req_divisor, req_tag};
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        rd_d    = pop ? rd_q + 1'b1 : rd_q;
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        state_d = state_q;
        cnt_d   = cnt_q;
        dd_d    = dd_q;
        dv_d    = dv_q;
        tag_d   = tag_q;
        dz_d    = dz_q;
        go_d    = go_q;
        rv_d    = rv_q & ~res_ready;
        rq_d    = rq_q;
        rt_d    = rt_q;
        rdz_d   = rdz_q;
        rto_d   = rto_q;
        case (state_q)
            IDLE: if (pop) begin
                dd_d    = head[EW-1 -: 32];
                dv_d    = head[TAG_W +: 16];
                tag_d   = head[TAG_W-1:0];
                dz_d    = head[TAG_W +: 16] == '0;
                cnt_d   = '0;
                go_d    = 1'b1;
                state_d = ISSUE;
            end
            ISSUE, BUSY: begin
                cnt_d = cnt_q + 8'd1;
                // result slot is known empty here, so loading never overwrites
                if (expired || (state_q == BUSY && dv_state == 3'b111)) begin
                    state_d = CAPTURE;
                    go_d    = 1'b0;
                    rv_d    = 1'b1;
                    rq_d    = (expired || dz_q) ? '0 : dv_quotient;
                    rt_d    = tag_q;
                    rdz_d   = dz_q;
                    rto_d   = expired;
                end else if (state_q == ISSUE && !dv_done) begin
                    state_d = BUSY;
                end
            end
            CAPTURE: state_d = RELEASE;
            RELEASE: state_d = dv_done ? IDLE : RELEASE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            cnt_q   <= '0;
            dd_q    <= '0;
            dv_q    <= '0;
            tag_q   <= '0;
            dz_q    <= 1'b0;
            go_q    <= 1'b0;
            rv_q    <= 1'b0;
            rq_q    <= '0;
            rt_q    <= '0;
            rdz_q   <= 1'b0;
            rto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            dd_q    <= dd_d;
            dv_q    <= dv_d;
            tag_q   <= tag_d;
            dz_q    <= dz_d;
            go_q    <= go_d;
            rv_q    <= rv_d;
            rq_q    <= rq_d;
            rt_q    <= rt_d;
            rdz_q   <= rdz_d;
            rto_q   <= rto_d;
        end
    end
endmodule
